// File: rtl/memory_stage_if.sv
// Execute-to-memory request bundle and write-back load result for memory_stage.
// The master side drives the MEM_* request and the slave side returns the flag and load data.
interface memory_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MEM_valid_i;
    logic                  MEM_stall_i;
    logic                  MEM_MemRead_i;
    logic                  MEM_MemWrite_i;
    logic [2:0]            MEM_funct3_i;
    logic [DATA_WIDTH-1:0] MEM_alu_result_i;
    logic [DATA_WIDTH-1:0] MEM_store_data_i;
    logic                  MEM_misaligned_o;
    logic [DATA_WIDTH-1:0] WB_load_data_o;
    logic                  WB_load_valid_o;

    modport master (
        output MEM_valid_i, MEM_stall_i, MEM_MemRead_i, MEM_MemWrite_i,
               MEM_funct3_i, MEM_alu_result_i, MEM_store_data_i,
        input  MEM_misaligned_o, WB_load_data_o, WB_load_valid_o
    );

    modport slave (
        input  MEM_valid_i, MEM_stall_i, MEM_MemRead_i, MEM_MemWrite_i,
               MEM_funct3_i, MEM_alu_result_i, MEM_store_data_i,
        output MEM_misaligned_o, WB_load_data_o, WB_load_valid_o
    );
endinterface

// File: rtl/memory_stage.sv
// RV32I memory stage: word-organised data memory with lane-enabled stores and extended loads.
// Define DMEM_MISALIGN_TRAP_EN to flag and block misaligned accesses instead of aligning them.
module memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus
);
    localparam int IDX_W = $clog2(DMEM_DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [DATA_WIDTH-1:0] mem [DMEM_DEPTH];

    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            addr_lane;
    logic [1:0]            lane;
    logic [2:0]            funct3;
    logic                  is_half;
    logic                  is_word;
    logic                  store_legal;
    logic                  load_legal;
    logic                  blocked_mis;
    logic                  misaligned;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  store_en;
    logic                  load_ok;
    logic                  addr_unused;

    logic [DATA_WIDTH-1:0] rd_word_q;
    logic [1:0]            lane_q;
    logic [2:0]            funct3_q;
    logic                  load_valid_q;

    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign word_idx    = bus.MEM_alu_result_i[2 +: IDX_W];
    assign addr_lane   = bus.MEM_alu_result_i[1:0];
    assign funct3      = bus.MEM_funct3_i;
    assign addr_unused = ^bus.MEM_alu_result_i[DATA_WIDTH-1:IDX_W+2];

    always_comb begin
        is_half     = (funct3 == F3_H) || (funct3 == F3_HU);
        is_word     = (funct3 == F3_W);
        store_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        load_legal  = store_legal || (funct3 == F3_BU) || (funct3 == F3_HU);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned_raw;

    assign misaligned_raw = (is_half && addr_lane[0]) || (is_word && (addr_lane != 2'b00));
    assign blocked_mis    = misaligned_raw;
    assign misaligned     = bus.MEM_valid_i && (bus.MEM_MemRead_i || bus.MEM_MemWrite_i)
                            && misaligned_raw;
    assign lane           = addr_lane;
`else
    // Without the trap, sub-word offsets that cannot hold the access are dropped.
    assign blocked_mis = 1'b0;
    assign misaligned  = 1'b0;
    assign lane        = is_word ? 2'b00 :
                         is_half ? {addr_lane[1], 1'b0} : addr_lane;
`endif

    assign bus.MEM_misaligned_o = misaligned;

    // Store lanes and lane-replicated write data.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = bus.MEM_store_data_i;
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{bus.MEM_store_data_i[7:0]}};
            end
            F3_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.MEM_store_data_i[15:0]}};
            end
            F3_W: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // rst_n gates the enable so a store coinciding with reset is dropped.
    assign store_en = rst_n && bus.MEM_valid_i && bus.MEM_MemWrite_i && !bus.MEM_stall_i
                      && store_legal && !blocked_mis;

    assign load_ok  = bus.MEM_valid_i && bus.MEM_MemRead_i && !bus.MEM_MemWrite_i
                      && load_legal && !blocked_mis;

    // NOTE: the memory array has no reset branch; clearing it would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the old word is captured
    // on the same edge a store updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_q    <= '0;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            load_valid_q <= 1'b0;
        end else if (!bus.MEM_stall_i) begin
            rd_word_q    <= mem[word_idx];
            lane_q       <= lane;
            funct3_q     <= funct3;
            load_valid_q <= load_ok;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel_byte  = rd_word_q[8*lane_q +: 8];
        sel_half  = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        load_data = '0;
        if (load_valid_q) begin
            case (funct3_q)
                F3_B:    load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
                F3_H:    load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
                F3_W:    load_data = rd_word_q;
                F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
                default: load_data = '0;
            endcase
        end
    end

    assign bus.WB_load_data_o  = load_data;
    assign bus.WB_load_valid_o = load_valid_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage with hand-computed expected load results.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_memory_stage;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    memory_stage_if #(.DATA_WIDTH(32)) bus ();

    memory_stage #(.DATA_WIDTH(32), .DMEM_DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.MEM_valid_i      = 1'b0;
        bus.MEM_stall_i      = 1'b0;
        bus.MEM_MemRead_i    = 1'b0;
        bus.MEM_MemWrite_i   = 1'b0;
        bus.MEM_funct3_i     = 3'b000;
        bus.MEM_alu_result_i = 32'h0;
        bus.MEM_store_data_i = 32'h0;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data);
        bus.MEM_valid_i      = 1'b1;
        bus.MEM_MemRead_i    = rd;
        bus.MEM_MemWrite_i   = wr;
        bus.MEM_funct3_i     = f3;
        bus.MEM_alu_result_i = addr;
        bus.MEM_store_data_i = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        present(1'b0, 1'b1, f3, addr, data);
        tick();
        idle();
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp_data, input logic exp_valid);
        present(1'b1, 1'b0, f3, addr, 32'h0);
        tick();
        idle();
        check(tag, bus.WB_load_data_o, exp_data);
        check({tag, "_valid"}, {31'h0, bus.WB_load_valid_o}, {31'h0, exp_valid});
    endtask

    initial begin
        logic        trap;
        logic [31:0] exp_lh41;
        logic [31:0] exp_w40;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        rst_n = 1'b0;
        idle();
        #2;
        check("reset_data", bus.WB_load_data_o, 32'h0);
        check("reset_valid", {31'h0, bus.WB_load_valid_o}, 32'h0);
        check("reset_misaligned", {31'h0, bus.MEM_misaligned_o}, 32'h0);
        #10;
        rst_n = 1'b1;
        tick();

        // Word store then load on the next cycle.
        store(3'b010, 32'h10, 32'h8765_4321);
        load_check("lw_10", 3'b010, 32'h10, 32'h8765_4321, 1'b1);

        // Byte store into lane 3.
        store(3'b000, 32'h13, 32'h1234_56AB);
        load_check("lb_13", 3'b000, 32'h13, 32'hFFFF_FFAB, 1'b1);
        load_check("lbu_13", 3'b100, 32'h13, 32'h0000_00AB, 1'b1);
        load_check("lw_10_after_sb", 3'b010, 32'h10, 32'hAB65_4321, 1'b1);

        // Upper halfword store.
        store(3'b010, 32'h20, 32'h1122_3344);
        store(3'b001, 32'h22, 32'hDEAD_8001);
        load_check("lh_22", 3'b001, 32'h22, 32'hFFFF_8001, 1'b1);
        load_check("lhu_22", 3'b101, 32'h22, 32'h0000_8001, 1'b1);
        load_check("lh_20", 3'b001, 32'h20, 32'h0000_3344, 1'b1);
        load_check("lw_20", 3'b010, 32'h20, 32'h8001_3344, 1'b1);

        // Misaligned halfword load and word store.
        store(3'b010, 32'h40, 32'hCAFE_F00D);
        present(1'b1, 1'b0, 3'b001, 32'h41, 32'h0);
        #1;
        check("lh_41_flag", {31'h0, bus.MEM_misaligned_o}, {31'h0, trap});
        tick();
        idle();
        exp_lh41 = trap ? 32'h0 : 32'hFFFF_F00D;
        check("lh_41", bus.WB_load_data_o, exp_lh41);
        check("lh_41_valid", {31'h0, bus.WB_load_valid_o}, {31'h0, !trap});

        present(1'b0, 1'b1, 3'b010, 32'h41, 32'h0102_0304);
        #1;
        check("sw_41_flag", {31'h0, bus.MEM_misaligned_o}, {31'h0, trap});
        tick();
        idle();
        check("idle_flag", {31'h0, bus.MEM_misaligned_o}, 32'h0);
        exp_w40 = trap ? 32'hCAFE_F00D : 32'h0102_0304;
        load_check("lw_40_after_sw41", 3'b010, 32'h40, exp_w40, 1'b1);

        // Stalled store commits only at the release edge; WB holds meanwhile.
        store(3'b010, 32'h30, 32'h0000_0000);
        store(3'b010, 32'h34, 32'h1111_1111);
        load_check("lw_10_pre_stall", 3'b010, 32'h10, 32'hAB65_4321, 1'b1);
        present(1'b0, 1'b1, 3'b010, 32'h30, 32'h5555_AAAA);
        bus.MEM_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_data", bus.WB_load_data_o, 32'hAB65_4321);
            check("stall_hold_valid", {31'h0, bus.WB_load_valid_o}, 32'h1);
        end
        bus.MEM_stall_i = 1'b0;
        tick();
        idle();
        check("release_valid", {31'h0, bus.WB_load_valid_o}, 32'h0);
        load_check("lw_30_after_stall", 3'b010, 32'h30, 32'h5555_AAAA, 1'b1);

        // A store abandoned while stalled never writes.
        present(1'b0, 1'b1, 3'b010, 32'h34, 32'h2222_2222);
        bus.MEM_stall_i = 1'b1;
        tick();
        tick();
        idle();
        tick();
        load_check("lw_34_dropped", 3'b010, 32'h34, 32'h1111_1111, 1'b1);

        // A stalled load is not captured.
        present(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        bus.MEM_stall_i = 1'b1;
        tick();
        check("stall_load_hold", bus.WB_load_data_o, 32'h1111_1111);
        idle();

        // Illegal funct3 writes nothing and loads invalid.
        store(3'b011, 32'h30, 32'hFFFF_FFFF);
        store(3'b100, 32'h30, 32'hFFFF_FFFF);
        load_check("lw_30_after_illegal", 3'b010, 32'h30, 32'h5555_AAAA, 1'b1);
        load_check("ld_illegal", 3'b011, 32'h30, 32'h0, 1'b0);

        // Read and write together: store lands, load is invalid.
        present(1'b1, 1'b1, 3'b010, 32'h38, 32'h7777_0000);
        tick();
        idle();
        check("rdwr_valid", {31'h0, bus.WB_load_valid_o}, 32'h0);
        load_check("lw_38", 3'b010, 32'h38, 32'h7777_0000, 1'b1);

        // Address wrap: 4*DMEM_DEPTH + 8 aliases 0x8.
        store(3'b010, 32'h1008, 32'h0BAD_BEEF);
        load_check("lw_8_alias", 3'b010, 32'h8, 32'h0BAD_BEEF, 1'b1);

        // Asynchronous reset clears WB outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", bus.WB_load_data_o, 32'h0);
        check("async_rst_valid", {31'h0, bus.WB_load_valid_o}, 32'h0);
        present(1'b0, 1'b1, 3'b010, 32'h8, 32'h1234_5678);
        tick();
        idle();
        #2;
        rst_n = 1'b1;
        tick();
        load_check("lw_8_store_in_reset", 3'b010, 32'h8, 32'h0BAD_BEEF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
